tt_um_anujic_div: RTL and testbench
===================================

# tt_um_anujic_div

Sequential 8-bit unsigned restoring divider for the TinyTapeout tile. It is the subtractive counterpart to the tile's combinational adder and uses the same pad-ring interface. The host loads a dividend and a divisor through `ui_in`, pulses start, and reads quotient or remainder on `uo_out` after a fixed latency. Control and status travel on the bidirectional `uio` pins.

## Interface
- No parameters. The data width is fixed at 8 by the pad ring.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: tile powered. Ignored.
- `ui_in` in 8: operand data bus.
- `uio_in` in 8: control inputs.
  - [0] `ld_a`: load dividend from `ui_in`.
  - [1] `ld_b`: load divisor from `ui_in`.
  - [2] `start`.
  - [3] `rd_sel`: 0 selects quotient, 1 selects remainder.
  - [7:4] ignored.
- `uo_out` out 8: `rd_sel ? rem_r : quo_r`, a combinational mux of result registers.
- `uio_out` out 8:
  - [3:0] = 0.
  - [4] `busy`.
  - [5] `done`.
  - [6] `dbz`: divide-by-zero flag.
  - [7] = 0.
- `uio_oe` out 8: constant 8'hF0.

## Operation
- Registers:
  - Operand registers: `a_r`, `b_r`.
  - Working registers: 8-bit partial remainder, 8-bit shifting dividend/quotient, 3-bit step counter.
  - Result registers: `quo_r`, `rem_r`, `dbz_r`.
  - State: IDLE, RUN, DONE.
- Reset (async, `rst_n`=0):
  - State is IDLE. Every register is 0.
  - Outputs: `uo_out`=0, `busy`=0, `done`=0, `dbz`=0.
  - `uio_oe`=8'hF0 at all times.
- Operand loads:
  - In IDLE or DONE, `ld_a`=1 writes `ui_in` to `a_r` at the edge, and `ld_b`=1 writes `ui_in` to `b_r`.
  - If both are high, both registers take `ui_in`.
  - In RUN, loads are ignored.
  - A load in DONE clears `done` (state goes to IDLE). It leaves results and `dbz` unchanged.
- Start, sampled in IDLE or DONE:
  - The computation uses `a_r`/`b_r` as they were before that edge. A load on the same edge still updates the register, for the next run.
  - If `b_r`==0: go directly to DONE. Set `quo_r`=8'hFF, `rem_r`=`a_r`, `dbz_r`=1.
  - Otherwise: clear `dbz_r`. Initialise partial remainder=0, shift register=`a_r`, counter=7. Go to RUN.
- Start sampled in RUN is ignored. There is no restart and no abort other than reset.
- RUN step, one per cycle:
  - Form `t` = {partial_rem[7:0], shift[7]} as 9 bits, then shift the register left by one.
  - If `t` ≥ `b_r`: partial_rem = `t` − `b_r` and the new LSB is 1. Otherwise partial_rem = `t[7:0]` and the LSB is 0.
  - The comparison must be 9-bit; no truncation before compare.
  - The counter decrements each step. On the step where the counter is 0, write `quo_r`/`rem_r` from the final working values and go to DONE.
- DONE:
  - `done`=1 holds until the next start or load.
  - Results hold until the next completed operation or reset.
- `uo_out` shows the previous results throughout RUN. It never shows intermediate values.
- `rd_sel` only muxes the output. It may change in any state and has no effect on state.

## Timing
- Start sampled at edge k with a nonzero divisor:
  - `busy`=1 from after edge k through edge k+8.
  - Results are valid and `done`=1 after edge k+8. Latency is 8 cycles.
  - Back-to-back operation: the next start may be sampled at edge k+9, giving a throughput of one division per 9 cycles.
- Start sampled at edge k with divisor 0: `done`=1 and `dbz`=1 after edge k, and `busy` never asserts.
- `busy` and `done` are never high together. `dbz` is valid whenever `done`=1.
- `uo_out` follows `rd_sel` combinationally, with zero-cycle latency.
- `rst_n` low mid-RUN: immediately IDLE, all zero. After release, the next start requires operands to be reloaded.

## Test plan
- Basic divide: load `a`=200, `b`=7, start at edge k. `busy` is high edges k..k+8. After k+8, `done`=1, `uo_out`=28 with `rd_sel`=0 and 4 with `rd_sel`=1.
- Divide by zero: `a`=123, `b`=0, start. After one edge, `done`=1, `dbz`=1, quotient 8'hFF, remainder 123, `busy` stays 0.
- Edge values:
  - 255/1 gives q=255, r=0.
  - 5/9 gives q=0, r=5.
  - 255/255 gives q=1, r=0.
  - 128/128 gives q=1, r=0.
  - A random sweep of 500 operand pairs matches a reference model.
- Ignored inputs during RUN: after starting 100/3, pulse start, `ld_a`=50 and `ld_b`=9 mid-RUN. The result is still q=33, r=1, and `a_r`/`b_r` are unchanged, so a new start yields 33/1 again.
- Same-edge load and start: `a_r`=60, `b_r`=6. Start together with `ld_a`=90. The result is 10 r0, and the next start gives 15 r0.
- Reset mid-RUN: assert `rst_n`=0 at cycle 4 of RUN. All outputs go 0 without waiting for a clock edge, `uio_oe` stays 8'hF0, and the state is IDLE after release.

Source files
------------

// File: rtl/tt_um_anujic_div.sv
// 8-bit unsigned restoring divider, one quotient bit per cycle.
// Ports: ui_in operand bus; uio_in {-,rd_sel,start,ld_b,ld_a}; uo_out result; uio_out {0,dbz,done,busy,0000}.
module tt_um_anujic_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [7:0] pr_q;
  logic [7:0] sh_q;
  logic [2:0] cnt_q;
  logic [7:0] quo_r;
  logic [7:0] rem_r;
  logic       dbz_r;

  logic ld_a;
  logic ld_b;
  logic start;
  logic rd_sel;

  assign ld_a   = uio_in[0];
  assign ld_b   = uio_in[1];
  assign start  = uio_in[2];
  assign rd_sel = uio_in[3];

  logic unused;
  assign unused = &{ena, uio_in[7:4]};

  logic [8:0] t;
  logic [8:0] diff;
  logic       ge;
  logic [7:0] pr_n;
  logic [7:0] sh_n;

  // Compare is done at 9 bits so a carried-out MSB is never lost.
  always_comb begin
    t    = {pr_q, sh_q[7]};
    diff = t - {1'b0, b_r};
    ge   = (t >= {1'b0, b_r});
    pr_n = ge ? diff[7:0] : t[7:0];
    sh_n = {sh_q[6:0], ge};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (cnt_q == 3'd0)
          state_d = DONE;
      end
      default: begin
        if (start)
          state_d = (b_r == 8'd0) ? DONE : RUN;
        else if (state_q == DONE && (ld_a || ld_b))
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      pr_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        pr_q  <= pr_n;
        sh_q  <= sh_n;
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          quo_r <= sh_n;
          rem_r <= pr_n;
        end
      end else begin
        if (ld_a)
          a_r <= ui_in;
        if (ld_b)
          b_r <= ui_in;
        // Start sees the operands from before this edge.
        if (start) begin
          if (b_r == 8'd0) begin
            quo_r <= 8'hFF;
            rem_r <= a_r;
            dbz_r <= 1'b1;
          end else begin
            dbz_r <= 1'b0;
            pr_q  <= '0;
            sh_q  <= a_r;
            cnt_q <= 3'd7;
          end
        end
      end
    end
  end

  assign uo_out  = rd_sel ? rem_r : quo_r;
  assign uio_out = {1'b0, dbz_r, state_q == DONE, state_q == RUN, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_anujic_div.sv
// Randomised self-checking bench for tt_um_anujic_div.
// A plain-arithmetic model is advanced before each edge and compared after it.
module tb_tt_um_anujic_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_anujic_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model: 0 idle, 1 run, 2 done
  int         m_st;
  int         m_left;
  logic [7:0] m_a, m_b, m_q, m_r, p_q, p_r;
  logic       m_dbz;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_st = 0; m_left = 0;
    m_a = 0; m_b = 0; m_q = 0; m_r = 0;
    p_q = 0; p_r = 0; m_dbz = 0;
  endtask

  task automatic compare();
    logic [7:0] exp_out;
    exp_out = {1'b0, m_dbz, m_st == 2, m_st == 1, 4'b0000};
    chk("uo_out", uo_out, uio_in[3] ? m_r : m_q);
    chk("uio_out", uio_out, exp_out);
    chk("uio_oe", uio_oe, 8'hF0);
  endtask

  // Advance model using the inputs present before the edge, then check.
  task automatic tick();
    logic la, lb, st;
    la = uio_in[0]; lb = uio_in[1]; st = uio_in[2];
    if (m_st == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_q = p_q; m_r = p_r; m_st = 2;
      end
    end else begin
      if (st) begin
        if (m_b == 0) begin
          m_q = 8'hFF; m_r = m_a; m_dbz = 1; m_st = 2;
        end else begin
          m_dbz = 0;
          p_q = m_a / m_b; p_r = m_a % m_b;
          m_left = 8; m_st = 1;
        end
      end else if (m_st == 2 && (la || lb)) begin
        m_st = 0;
      end
      if (la) m_a = ui_in;
      if (lb) m_b = ui_in;
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [7:0] d);
    ui_in = d;
    uio_in = {4'b0, uio_in[3], ctl};
    tick();
    uio_in[2:0] = 3'b000;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_st != 2 && n < 12) begin
      uio_in[3] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    vectors++;
    if (uio_out[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: done=%b expected 1", uio_out[5]);
    end
  endtask

  task automatic read_lit(input string name, input logic [7:0] q,
                          input logic [7:0] r);
    uio_in[3] = 1'b0; #1;
    chk({name, "_q"}, uo_out, q);
    uio_in[3] = 1'b1; #1;
    chk({name, "_r"}, uo_out, r);
  endtask

  task automatic divide(input logic [7:0] a, input logic [7:0] b);
    drive(3'b001, a);
    drive(3'b010, b);
    drive(3'b100, 8'h00);
    wait_done();
  endtask

  initial begin
    model_clear();
    #3;
    #1 compare();
    chk("rst_uo", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic divide with cycle-accurate busy window.
    drive(3'b001, 8'd200);
    drive(3'b010, 8'd7);
    drive(3'b100, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("busy_lit", {7'b0, uio_out[4]}, 8'd1);
      tick();
    end
    chk("done_lit", {7'b0, uio_out[5]}, 8'd1);
    chk("busy_off", {7'b0, uio_out[4]}, 8'd0);
    read_lit("basic", 8'd28, 8'd4);

    // Divide by zero.
    drive(3'b001, 8'd123);
    drive(3'b010, 8'd0);
    drive(3'b100, 8'h00);
    chk("dbz_flag", {7'b0, uio_out[6]}, 8'd1);
    chk("dbz_busy", {7'b0, uio_out[4]}, 8'd0);
    read_lit("dbz", 8'hFF, 8'd123);

    divide(8'd255, 8'd1);   read_lit("e255_1", 8'd255, 8'd0);
    divide(8'd5, 8'd9);     read_lit("e5_9", 8'd0, 8'd5);
    divide(8'd255, 8'd255); read_lit("e255_255", 8'd1, 8'd0);
    divide(8'd128, 8'd128); read_lit("e128_128", 8'd1, 8'd0);
    divide(8'd254, 8'd128); read_lit("e254_128", 8'd1, 8'd126);

    // Inputs ignored during RUN.
    drive(3'b001, 8'd100);
    drive(3'b010, 8'd3);
    drive(3'b100, 8'h00);
    tick();
    drive(3'b101, 8'd50);
    drive(3'b010, 8'd9);
    wait_done();
    read_lit("ign1", 8'd33, 8'd1);
    drive(3'b100, 8'h00);
    wait_done();
    read_lit("ign2", 8'd33, 8'd1);

    // Load on the same edge as start.
    drive(3'b001, 8'd60);
    drive(3'b010, 8'd6);
    drive(3'b101, 8'd90);
    wait_done();
    read_lit("same1", 8'd10, 8'd0);
    drive(3'b100, 8'h00);
    wait_done();
    read_lit("same2", 8'd15, 8'd0);

    // Load in DONE clears done but keeps results.
    drive(3'b001, 8'd1);
    read_lit("ldkeep", 8'd15, 8'd0);

    // Random sweep, occasionally with zero divisor.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom);
      divide(a, b);
      if (b != 0) read_lit("rand", a / b, a % b);
      else read_lit("rand0", 8'hFF, a);
    end

    // Reset in the middle of RUN.
    divide(8'd77, 8'd5);
    drive(3'b100, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_uo", uo_out, 8'h00);
    chk("mid_rst_uio", uio_out, 8'h00);
    chk("mid_rst_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", uio_out, 8'h00);
    drive(3'b100, 8'h00);
    read_lit("post_rst_dbz", 8'hFF, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
